// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates entries at issue, renames destinations,
// captures CDB results and retires the head in program order with branch-mispredict flush.
module reorder_buffer #(
  parameter int ROB_SIZE  = 8,
  parameter int ID_WIDTH  = 4,
  parameter int REG_WIDTH = 5,
  parameter int VAL_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 iss_valid,
  input  logic [1:0]           iss_type,
  input  logic [REG_WIDTH-1:0] iss_rd,
  input  logic [VAL_WIDTH-1:0] iss_alt_pc,
  output logic                 rob_full,
  output logic [ID_WIDTH-1:0]  iss_tag,
  output logic [REG_WIDTH-1:0] rob2rf_rd,
  output logic [ID_WIDTH-1:0]  rob2rf_tag,
  output logic [REG_WIDTH-1:0] rob2rf_commit_rd,
  output logic [VAL_WIDTH-1:0] rob2rf_commit_res,
  output logic [ID_WIDTH-1:0]  rob2rf_commit_lab,
  input  logic                 cdb_valid,
  input  logic [ID_WIDTH-1:0]  cdb_tag,
  input  logic [VAL_WIDTH-1:0] cdb_val,
  input  logic                 cdb_mispred,
  input  logic [ID_WIDTH-1:0]  qry_tag1,
  input  logic [ID_WIDTH-1:0]  qry_tag2,
  output logic                 qry_rdy1,
  output logic                 qry_rdy2,
  output logic [VAL_WIDTH-1:0] qry_val1,
  output logic [VAL_WIDTH-1:0] qry_val2,
  output logic                 st_commit,
  output logic [ID_WIDTH-1:0]  st_commit_tag,
  output logic                 flush,
  output logic [VAL_WIDTH-1:0] flush_pc
);

  localparam int PTR_W = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;
  localparam int CNT_W = $clog2(ROB_SIZE + 1);
  localparam logic [1:0] TYPE_REG = 2'd0;
  localparam logic [1:0] TYPE_BR  = 2'd1;
  localparam logic [1:0] TYPE_ST  = 2'd2;

  logic [PTR_W-1:0]     head_reg, tail_reg;
  logic [CNT_W-1:0]     count_reg;
  logic [ROB_SIZE-1:0]  valid_reg, ready_reg, mispred_reg;
  logic [1:0]           type_mem   [ROB_SIZE];
  logic [REG_WIDTH-1:0] rd_mem     [ROB_SIZE];
  logic [VAL_WIDTH-1:0] alt_pc_mem [ROB_SIZE];
  logic [VAL_WIDTH-1:0] value_mem  [ROB_SIZE];

  logic                 issue_accept, retire, flush_now, cdb_capture, cdb_in_range;
  logic [PTR_W-1:0]     cdb_idx;
  logic [ID_WIDTH-1:0]  head_tag;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(ROB_SIZE - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign rob_full     = (count_reg == CNT_W'(ROB_SIZE));
  assign iss_tag      = ID_WIDTH'(tail_reg) + ID_WIDTH'(1);
  assign head_tag     = ID_WIDTH'(head_reg) + ID_WIDTH'(1);
  assign issue_accept = rdy_in && iss_valid && !rob_full && !flush;
  assign retire       = rdy_in && !flush && (count_reg != '0) && ready_reg[head_reg];
  assign flush_now    = retire && (type_mem[head_reg] == TYPE_BR) && mispred_reg[head_reg];

  assign cdb_idx      = PTR_W'(cdb_tag - ID_WIDTH'(1));
  assign cdb_in_range = (cdb_tag != '0) && (cdb_tag <= ID_WIDTH'(ROB_SIZE));
  assign cdb_capture  = rdy_in && !flush && cdb_valid && cdb_in_range && valid_reg[cdb_idx];

  // Rename is combinational so the register file tags rd on the allocating edge.
  assign rob2rf_rd  = (issue_accept && iss_type == TYPE_REG) ? iss_rd : '0;
  assign rob2rf_tag = rdy_in ? iss_tag : '0;

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      head_reg          <= '0;
      tail_reg          <= '0;
      count_reg         <= '0;
      valid_reg         <= '0;
      ready_reg         <= '0;
      mispred_reg       <= '0;
      rob2rf_commit_rd  <= '0;
      rob2rf_commit_res <= '0;
      rob2rf_commit_lab <= '0;
      st_commit         <= 1'b0;
      st_commit_tag     <= '0;
      flush             <= 1'b0;
      flush_pc          <= '0;
    end else if (rdy_in) begin
      rob2rf_commit_rd  <= '0;
      rob2rf_commit_res <= '0;
      rob2rf_commit_lab <= '0;
      st_commit         <= 1'b0;
      st_commit_tag     <= '0;
      flush             <= 1'b0;
      flush_pc          <= '0;
      if (flush_now) begin
        // Everything younger than the mispredicted branch is wrong-path work.
        head_reg    <= '0;
        tail_reg    <= '0;
        count_reg   <= '0;
        valid_reg   <= '0;
        ready_reg   <= '0;
        mispred_reg <= '0;
        flush       <= 1'b1;
        flush_pc    <= alt_pc_mem[head_reg];
      end else begin
        if (issue_accept) begin
          valid_reg[tail_reg]   <= 1'b1;
          ready_reg[tail_reg]   <= (iss_type == TYPE_ST);
          mispred_reg[tail_reg] <= 1'b0;
          tail_reg              <= ptr_inc(tail_reg);
        end
        if (cdb_capture) begin
          ready_reg[cdb_idx]   <= 1'b1;
          mispred_reg[cdb_idx] <= cdb_mispred;
        end
        if (retire) begin
          valid_reg[head_reg] <= 1'b0;
          head_reg            <= ptr_inc(head_reg);
          if (type_mem[head_reg] == TYPE_REG) begin
            rob2rf_commit_rd  <= rd_mem[head_reg];
            rob2rf_commit_res <= value_mem[head_reg];
            rob2rf_commit_lab <= head_tag;
          end else if (type_mem[head_reg] == TYPE_ST) begin
            st_commit     <= 1'b1;
            st_commit_tag <= head_tag;
          end
        end
        case ({issue_accept, retire})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  // Payload storage carries no reset; the valid/ready bits qualify every read.
  always_ff @(posedge clk) begin
    if (issue_accept) begin
      type_mem[tail_reg]   <= iss_type;
      rd_mem[tail_reg]     <= iss_rd;
      alt_pc_mem[tail_reg] <= iss_alt_pc;
      value_mem[tail_reg]  <= '0;
    end
    if (cdb_capture) begin
      value_mem[cdb_idx] <= cdb_val;
    end
  end

  logic [1:0][ID_WIDTH-1:0] qry_tag;
  logic [1:0]               qry_rdy;
  logic [VAL_WIDTH-1:0]     qry_val [2];

  assign qry_tag = {qry_tag2, qry_tag1};

  for (genvar gi = 0; gi < 2; gi++) begin : g_qry
    logic [PTR_W-1:0] idx;
    logic             hit;
    logic             bypass;
    assign idx    = PTR_W'(qry_tag[gi] - ID_WIDTH'(1));
    assign hit    = (qry_tag[gi] != '0) && (qry_tag[gi] <= ID_WIDTH'(ROB_SIZE)) && valid_reg[idx];
    assign bypass = cdb_valid && (cdb_tag == qry_tag[gi]);
    assign qry_rdy[gi] = hit && (bypass || ready_reg[idx]);
    assign qry_val[gi] = !hit            ? '0 :
                         bypass          ? cdb_val :
                         ready_reg[idx]  ? value_mem[idx] : '0;
  end

  assign qry_rdy1 = qry_rdy[0];
  assign qry_rdy2 = qry_rdy[1];
  assign qry_val1 = qry_val[0];
  assign qry_val2 = qry_val[1];

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: rename, in-order commit, bypass,
// store retirement, full/refusal, mispredict flush, wrap-around and rdy_in freeze.
module tb_reorder_buffer;
  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in, iss_valid, cdb_valid, cdb_mispred;
  logic [1:0]  iss_type;
  logic [4:0]  iss_rd;
  logic [31:0] iss_alt_pc, cdb_val;
  logic [3:0]  cdb_tag, qry_tag1, qry_tag2;
  logic        rob_full, qry_rdy1, qry_rdy2, st_commit, flush;
  logic [3:0]  iss_tag, rob2rf_tag, rob2rf_commit_lab, st_commit_tag;
  logic [4:0]  rob2rf_rd, rob2rf_commit_rd;
  logic [31:0] rob2rf_commit_res, qry_val1, qry_val2, flush_pc;

  int n_vec = 0;
  int n_err = 0;

  reorder_buffer #(.ROB_SIZE(8), .ID_WIDTH(4), .REG_WIDTH(5), .VAL_WIDTH(32)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in),
    .iss_valid(iss_valid), .iss_type(iss_type), .iss_rd(iss_rd), .iss_alt_pc(iss_alt_pc),
    .rob_full(rob_full), .iss_tag(iss_tag), .rob2rf_rd(rob2rf_rd), .rob2rf_tag(rob2rf_tag),
    .rob2rf_commit_rd(rob2rf_commit_rd), .rob2rf_commit_res(rob2rf_commit_res),
    .rob2rf_commit_lab(rob2rf_commit_lab),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val), .cdb_mispred(cdb_mispred),
    .qry_tag1(qry_tag1), .qry_tag2(qry_tag2), .qry_rdy1(qry_rdy1), .qry_rdy2(qry_rdy2),
    .qry_val1(qry_val1), .qry_val2(qry_val2),
    .st_commit(st_commit), .st_commit_tag(st_commit_tag), .flush(flush), .flush_pc(flush_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic idle();
    rdy_in = 1'b1; iss_valid = 1'b0; iss_type = 2'd0; iss_rd = '0; iss_alt_pc = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; cdb_mispred = 1'b0;
    qry_tag1 = '0; qry_tag2 = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    idle();
    step();
    settle();
    n_vec++; if (rob_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %0h expected 0", rob_full); end
    n_vec++; if (iss_tag !== 4'd1) begin n_err++; $display("FAIL reset_iss_tag: got %0h expected 1", iss_tag); end
    n_vec++; if (flush !== 1'b0 || flush_pc !== 32'd0) begin n_err++; $display("FAIL reset_flush: got %0h/%0h expected 0/0", flush, flush_pc); end
    n_vec++; if (st_commit !== 1'b0 || st_commit_tag !== 4'd0) begin n_err++; $display("FAIL reset_st: got %0h/%0h expected 0/0", st_commit, st_commit_tag); end
    n_vec++; if (rob2rf_commit_rd !== 5'd0 || rob2rf_commit_res !== 32'd0 || rob2rf_commit_lab !== 4'd0) begin n_err++; $display("FAIL reset_commit_bus: got %0h/%0h/%0h expected 0/0/0", rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab); end
    rst_in = 1'b0;
    step();
    $display("test_reset done");
  endtask

  task automatic test_rename();
    idle(); iss_valid = 1'b1; iss_rd = 5'd5;
    settle();
    n_vec++; if (iss_tag !== 4'd1) begin n_err++; $display("FAIL rename1_tag: got %0h expected 1", iss_tag); end
    n_vec++; if (rob2rf_rd !== 5'd5 || rob2rf_tag !== 4'd1) begin n_err++; $display("FAIL rename1_rf: got rd %0h tag %0h expected 5/1", rob2rf_rd, rob2rf_tag); end
    n_vec++; if (rob_full !== 1'b0) begin n_err++; $display("FAIL rename1_full: got %0h expected 0", rob_full); end
    step();
    iss_rd = 5'd6;
    settle();
    n_vec++; if (iss_tag !== 4'd2 || rob2rf_rd !== 5'd6 || rob2rf_tag !== 4'd2) begin n_err++; $display("FAIL rename2: got tag %0h rd %0h rftag %0h expected 2/6/2", iss_tag, rob2rf_rd, rob2rf_tag); end
    step();
    idle();
    settle();
    n_vec++; if (iss_tag !== 4'd3 || rob2rf_rd !== 5'd0) begin n_err++; $display("FAIL rename_idle: got tag %0h rd %0h expected 3/0", iss_tag, rob2rf_rd); end
    $display("test_rename done");
  endtask

  task automatic test_in_order_commit();
    idle(); qry_tag1 = 4'd1; cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_val = 32'h22;
    settle();
    n_vec++; if (qry_rdy1 !== 1'b0 || qry_val1 !== 32'd0) begin n_err++; $display("FAIL qry_not_ready: got %0h/%0h expected 0/0", qry_rdy1, qry_val1); end
    step();
    n_vec++; if (rob2rf_commit_lab !== 4'd0) begin n_err++; $display("FAIL no_early_commit: got lab %0h expected 0", rob2rf_commit_lab); end
    idle(); qry_tag1 = 4'd1; qry_tag2 = 4'd2; cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'h11;
    settle();
    n_vec++; if (qry_rdy1 !== 1'b1 || qry_val1 !== 32'h11) begin n_err++; $display("FAIL qry1_bypass: got %0h/%0h expected 1/11", qry_rdy1, qry_val1); end
    n_vec++; if (qry_rdy2 !== 1'b1 || qry_val2 !== 32'h22) begin n_err++; $display("FAIL qry2_stored: got %0h/%0h expected 1/22", qry_rdy2, qry_val2); end
    step();
    n_vec++; if (rob2rf_commit_rd !== 5'd0) begin n_err++; $display("FAIL commit_capture_edge: got rd %0h expected 0", rob2rf_commit_rd); end
    idle();
    step();
    n_vec++; if (rob2rf_commit_rd !== 5'd5 || rob2rf_commit_res !== 32'h11 || rob2rf_commit_lab !== 4'd1) begin n_err++; $display("FAIL commit1: got %0h/%0h/%0h expected 5/11/1", rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab); end
    step();
    n_vec++; if (rob2rf_commit_rd !== 5'd6 || rob2rf_commit_res !== 32'h22 || rob2rf_commit_lab !== 4'd2) begin n_err++; $display("FAIL commit2: got %0h/%0h/%0h expected 6/22/2", rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab); end
    step();
    n_vec++; if (rob2rf_commit_rd !== 5'd0 || rob2rf_commit_res !== 32'd0 || rob2rf_commit_lab !== 4'd0) begin n_err++; $display("FAIL commit_idle: got %0h/%0h/%0h expected 0/0/0", rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab); end
    $display("test_in_order_commit done");
  endtask

  task automatic test_flush();
    idle(); iss_valid = 1'b1; iss_type = 2'd1; iss_rd = 5'd3; iss_alt_pc = 32'h100;
    settle();
    n_vec++; if (iss_tag !== 4'd3 || rob2rf_rd !== 5'd0 || rob2rf_tag !== 4'd3) begin n_err++; $display("FAIL branch_issue: got tag %0h rd %0h rftag %0h expected 3/0/3", iss_tag, rob2rf_rd, rob2rf_tag); end
    step();
    idle(); iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    iss_rd = 5'd8;
    step();
    idle(); cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_mispred = 1'b1;
    step();
    n_vec++; if (flush !== 1'b0) begin n_err++; $display("FAIL flush_early: got %0h expected 0", flush); end
    idle();
    step();
    n_vec++; if (flush !== 1'b1 || flush_pc !== 32'h100) begin n_err++; $display("FAIL flush_pulse: got %0h pc %0h expected 1/100", flush, flush_pc); end
    n_vec++; if (iss_tag !== 4'd1 || rob_full !== 1'b0 || rob2rf_commit_lab !== 4'd0) begin n_err++; $display("FAIL flush_clear: got tag %0h full %0h lab %0h expected 1/0/0", iss_tag, rob_full, rob2rf_commit_lab); end
    iss_valid = 1'b1; iss_rd = 5'd9;
    settle();
    n_vec++; if (rob2rf_rd !== 5'd0) begin n_err++; $display("FAIL flush_issue_refused: got rd %0h expected 0", rob2rf_rd); end
    step();
    n_vec++; if (flush !== 1'b0 || iss_tag !== 4'd1) begin n_err++; $display("FAIL flush_after: got flush %0h tag %0h expected 0/1", flush, iss_tag); end
    idle();
    $display("test_flush done");
  endtask

  task automatic test_query_bypass();
    idle(); iss_valid = 1'b1; iss_rd = 5'd10;
    settle();
    n_vec++; if (iss_tag !== 4'd1) begin n_err++; $display("FAIL bypass_issue_tag: got %0h expected 1", iss_tag); end
    step();
    idle(); cdb_valid = 1'b1; cdb_tag = 4'd1; cdb_val = 32'hAB; qry_tag1 = 4'd1; qry_tag2 = 4'd2;
    settle();
    n_vec++; if (qry_rdy1 !== 1'b1 || qry_val1 !== 32'hAB) begin n_err++; $display("FAIL bypass_qry1: got %0h/%0h expected 1/ab", qry_rdy1, qry_val1); end
    n_vec++; if (qry_rdy2 !== 1'b0 || qry_val2 !== 32'd0) begin n_err++; $display("FAIL invalid_qry2: got %0h/%0h expected 0/0", qry_rdy2, qry_val2); end
    step();
    idle(); qry_tag1 = 4'd1;
    settle();
    n_vec++; if (qry_rdy1 !== 1'b1 || qry_val1 !== 32'hAB) begin n_err++; $display("FAIL stored_qry1: got %0h/%0h expected 1/ab", qry_rdy1, qry_val1); end
    step();
    n_vec++; if (rob2rf_commit_rd !== 5'd10 || rob2rf_commit_res !== 32'hAB || rob2rf_commit_lab !== 4'd1) begin n_err++; $display("FAIL bypass_commit: got %0h/%0h/%0h expected a/ab/1", rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab); end
    idle();
    $display("test_query_bypass done");
  endtask

  task automatic test_back_to_back_stores();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 5) begin
        iss_valid = 1'b1; iss_type = 2'd2; iss_rd = 5'(i + 1);
        settle();
        n_vec++; if (iss_tag !== 4'(2 + i) || rob2rf_rd !== 5'd0) begin n_err++; $display("FAIL store_issue%0d: got tag %0h rd %0h expected %0h/0", i, iss_tag, rob2rf_rd, 4'(2 + i)); end
      end
      step();
      if (i >= 1) begin
        n_vec++; if (st_commit !== 1'b1 || st_commit_tag !== 4'(i + 1) || rob2rf_commit_rd !== 5'd0) begin n_err++; $display("FAIL store_commit%0d: got st %0h tag %0h rd %0h expected 1/%0h/0", i, st_commit, st_commit_tag, rob2rf_commit_rd, 4'(i + 1)); end
      end
    end
    idle();
    step();
    n_vec++; if (st_commit !== 1'b0) begin n_err++; $display("FAIL store_idle: got %0h expected 0", st_commit); end
    $display("test_back_to_back_stores done");
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) begin
      idle(); iss_valid = 1'b1; iss_rd = 5'(i + 1);
      settle();
      n_vec++; if (iss_tag !== 4'((6 + i) % 8 + 1) || rob_full !== 1'b0) begin n_err++; $display("FAIL fill%0d: got tag %0h full %0h expected %0h/0", i, iss_tag, rob_full, 4'((6 + i) % 8 + 1)); end
      step();
    end
    idle();
    settle();
    n_vec++; if (rob_full !== 1'b1 || iss_tag !== 4'd7) begin n_err++; $display("FAIL full_after8: got full %0h tag %0h expected 1/7", rob_full, iss_tag); end
    iss_valid = 1'b1; iss_rd = 5'd31;
    settle();
    n_vec++; if (rob2rf_rd !== 5'd0) begin n_err++; $display("FAIL ninth_refused_rd: got %0h expected 0", rob2rf_rd); end
    step();
    n_vec++; if (iss_tag !== 4'd7 || rob_full !== 1'b1) begin n_err++; $display("FAIL ninth_refused_tail: got tag %0h full %0h expected 7/1", iss_tag, rob_full); end
    idle();
    $display("test_full done");
  endtask

  task automatic test_commit_six();
    for (int i = 0; i < 7; i++) begin
      idle();
      if (i < 6) begin
        cdb_valid = 1'b1; cdb_tag = 4'((6 + i) % 8 + 1); cdb_val = 32'h1000 + 32'(i);
      end
      if (i == 1) begin
        iss_valid = 1'b1; iss_rd = 5'd30;
        settle();
        n_vec++; if (rob2rf_rd !== 5'd0) begin n_err++; $display("FAIL full_while_retiring: got rd %0h expected 0", rob2rf_rd); end
      end
      step();
      if (i >= 1) begin
        n_vec++; if (rob2rf_commit_lab !== 4'((5 + i) % 8 + 1) || rob2rf_commit_rd !== 5'(i) || rob2rf_commit_res !== 32'h1000 + 32'(i - 1)) begin n_err++; $display("FAIL commit_seq%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", i, rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab, i, 32'h1000 + 32'(i - 1), (5 + i) % 8 + 1); end
      end
    end
    $display("test_commit_six done");
  endtask

  task automatic test_freeze();
    idle(); rdy_in = 1'b0; iss_valid = 1'b1; iss_rd = 5'd20;
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_val = 32'h55;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_vec++; if (rob2rf_rd !== 5'd0 || rob2rf_tag !== 4'd0) begin n_err++; $display("FAIL freeze_rename%0d: got rd %0h tag %0h expected 0/0", i, rob2rf_rd, rob2rf_tag); end
      step();
      n_vec++; if (rob2rf_commit_lab !== 4'd4 || rob2rf_commit_rd !== 5'd6 || rob2rf_commit_res !== 32'h1005 || iss_tag !== 4'd7) begin n_err++; $display("FAIL freeze_hold%0d: got %0h/%0h/%0h tag %0h expected 6/1005/4 tag 7", i, rob2rf_commit_rd, rob2rf_commit_res, rob2rf_commit_lab, iss_tag); end
    end
    idle(); qry_tag1 = 4'd5;
    settle();
    n_vec++; if (qry_rdy1 !== 1'b0) begin n_err++; $display("FAIL freeze_cdb_ignored: got %0h expected 0", qry_rdy1); end
    step();
    n_vec++; if (rob2rf_commit_lab !== 4'd0) begin n_err++; $display("FAIL unfreeze_bus: got lab %0h expected 0", rob2rf_commit_lab); end
    $display("test_freeze done");
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 6; i++) begin
      idle(); iss_valid = 1'b1; iss_rd = 5'(11 + i);
      settle();
      n_vec++; if (iss_tag !== 4'((6 + i) % 8 + 1) || rob2rf_tag !== 4'((6 + i) % 8 + 1) || rob2rf_rd !== 5'(11 + i)) begin n_err++; $display("FAIL wrap%0d: got tag %0h rftag %0h rd %0h expected %0h/%0h/%0h", i, iss_tag, rob2rf_tag, rob2rf_rd, (6 + i) % 8 + 1, (6 + i) % 8 + 1, 11 + i); end
      step();
    end
    idle();
    settle();
    n_vec++; if (rob_full !== 1'b1 || iss_tag !== 4'd5) begin n_err++; $display("FAIL wrap_full: got full %0h tag %0h expected 1/5", rob_full, iss_tag); end
    $display("test_wrap done");
  endtask

  task automatic test_async_reset();
    rst_in = 1'b1;
    #1;
    n_vec++; if (rob_full !== 1'b0 || iss_tag !== 4'd1) begin n_err++; $display("FAIL async_reset: got full %0h tag %0h expected 0/1", rob_full, iss_tag); end
    step();
    rst_in = 1'b0;
    step();
    $display("test_async_reset done");
  endtask

  initial begin
    idle();
    test_reset();
    test_rename();
    test_in_order_commit();
    test_flush();
    test_query_bypass();
    test_back_to_back_stores();
    test_full();
    test_commit_six();
    test_freeze();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order reorder buffer for the Tomasulo RISC-V core.
- Allocates one entry per issued instruction, renames the destination in the register file, and captures results from the common data bus (CDB).
- Retires the head in program order, one entry per cycle, writing results back to the register file.
- Raises flush with a redirect PC when a mispredicted branch retires.

Parameters:
ROB_SIZE, 8, number of entries; must satisfy ROB_SIZE <= 2^ID_WIDTH - 1.
ID_WIDTH, 4, tag width; tag 0 means "no producer"; entry i carries tag i+1.
REG_WIDTH, 5, architectural register index width.
VAL_WIDTH, 32, data width.

Ports:
clk  in  1  clock; all state on rising edge.
rst_in  in  1  asynchronous, active-high reset.
rdy_in  in  1  global enable; low freezes all state.
iss_valid  in  1  decoder presents an instruction.
iss_type  in  2  0=reg-writing op, 1=branch, 2=store.
iss_rd  in  REG_WIDTH  destination register; ignored unless iss_type=0.
iss_alt_pc  in  VAL_WIDTH  branch recovery PC (the non-predicted path).
rob_full  out  1  count==ROB_SIZE; issue is refused.
iss_tag  out  ID_WIDTH  tag allocated this cycle (tail+1).
rob2rf_rd  out  REG_WIDTH  rename destination; 0 means no rename.
rob2rf_tag  out  ID_WIDTH  rename tag.
rob2rf_commit_rd  out  REG_WIDTH  retiring destination; 0 means none.
rob2rf_commit_res  out  VAL_WIDTH  retiring value.
rob2rf_commit_lab  out  ID_WIDTH  retiring tag.
cdb_valid  in  1  result broadcast.
cdb_tag  in  ID_WIDTH  producer tag.
cdb_val  in  VAL_WIDTH  result value.
cdb_mispred  in  1  branch outcome differs from prediction.
qry_tag1, qry_tag2  in  ID_WIDTH  operand lookup tags.
qry_rdy1, qry_rdy2  out  1  queried entry holds its result.
qry_val1, qry_val2  out  VAL_WIDTH  queried value.
st_commit  out  1  registered pulse: store at head retired.
st_commit_tag  out  ID_WIDTH  tag of that store.
flush  out  1  registered one-cycle pulse.
flush_pc  out  VAL_WIDTH  redirect target.

Behaviour:
- Reset (async) clears head, tail, count, and all valid/ready bits. All registered outputs are 0, including flush, flush_pc, st_commit, and the commit bus.
- Issue accept condition: rdy_in && iss_valid && !rob_full && !flush. On accept, entry[tail] takes type, rd, alt_pc, ready=0, mispred=0. tail wraps ROB_SIZE-1 to 0; count increments.
- Rename outputs are combinational, so the register file tags rd on the same edge as allocation.
  - rob2rf_rd = iss_rd when accepted and iss_type=0; otherwise 0.
  - rob2rf_tag = iss_tag.
- CDB capture: when cdb_valid, cdb_tag!=0, and the entry for tag-1 is valid, set ready=1 and store cdb_val and cdb_mispred.
- Stores: ready=1 at allocation.
- Query: combinational. rdy/val come from entry[tag-1]. A CDB broadcast of the same tag in the same cycle bypasses the entry (rdy=1, val=cdb_val). Tag 0 or an invalid entry gives rdy=0, val=0.
- Commit: when rdy_in && count>0 && entry[head].ready, retire head. head wraps and count decrements. On the next edge:
  - type 0: commit_rd/res/lab = rd/value/head+1.
  - type 2: st_commit=1, st_commit_tag=head+1.
  - type 1 with mispred=1: flush=1, flush_pc=alt_pc. On the same edge, head, tail, count, and all valid bits clear.
  - In the cycle after any retirement, the commit bus returns to 0 unless another retirement occurs.
- The commit bus is registered; the register file applies it one cycle after the retire decision.
- Same-cycle issue and commit: count stays unchanged. rob_full is computed from the pre-edge count, so no issue is accepted while full even if the head retires.
- During the flush-high cycle: issue is refused, CDB is ignored, and no retirement occurs.
- rdy_in low: no state change; combinational rename outputs are forced to 0.
- Reset asserted mid-operation discards all entries immediately.

Test Plan:
- Reset, then issue add x5, add x6 -> iss_tag 1, 2; rob2rf_rd=5/6 with tag 1/2; rob_full=0, count 2.
- Issue 8 ops with no CDB -> rob_full=1 after the 8th. A 9th iss_valid is refused and tail is unchanged.
- CDB tag2=0x22 then tag1=0x11 -> commits in order: rd5/0x11/lab1, then rd6/0x22/lab2, on consecutive cycles.
- Query tag1 while CDB broadcasts tag1=0xAB in the same cycle -> qry_rdy1=1, qry_val1=0xAB.
- Branch (alt_pc 0x100), then 2 ops; CDB branch with mispred=1 -> flush pulse with flush_pc=0x100, count 0, next iss_tag=1.
- Commit 6 entries, then issue 6 more -> tail wraps, iss_tag sequence 7,8,1,2,3,4. Hold rdy_in low 3 cycles mid-run -> outputs and state frozen.
